param_bus_datapath: RTL and testbench
=====================================

Name: param_bus_datapath

Overview:
- Next-generation single-bus CPU datapath, parametrised in data width and register count.
- Contains a general register file, PC, IR, MAR, MDR, Y, a 2W-bit Z, and HI/LO, all sharing one internal bus.
- Adds a multi-cycle signed multiply/divide unit with a start/busy/done handshake, bus-contention detection and a debug read port.
- Sits under the control unit, which drives all one-hot in/out strobes.

Parameters:
- WIDTH, 32, data/bus width in bits; must be a power of two, 8..64.
- NREGS, 16, number of general registers; 2..32; R0 is special, see ba_out.
- PC_STEP, 1, increment applied by inc_pc.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- reg_in  in  NREGS  one-hot general register load strobes
- reg_out  in  NREGS  one-hot general register bus-drive strobes
- ba_out  in  1  when high, R0 drives zero onto the bus instead of its contents
- pc_in, pc_out, inc_pc  in  1 each  PC load, PC drive, PC increment
- ir_in, mar_in, y_in, hi_in, lo_in  in  1 each  register load strobes
- mdr_in, mdr_read, mdr_out  in  1 each  MDR load, MDR source select (1 = mdata_in, 0 = bus), MDR drive
- z_in  in  1  load Z from the combinational ALU result
- zhi_out, zlo_out, hi_out, lo_out, c_out, inport_out  in  1 each  bus-drive strobes
- c_data  in  WIDTH  sign-extended immediate
- inport_data  in  WIDTH  input port value
- mdata_in  in  WIDTH  memory read data
- alu_op  in  5  operation code, from the package
- start  in  1  begin MUL/DIV
- busy  out  1  multiply/divide in progress
- done  out  1  one-cycle completion pulse
- div0  out  1  sticky flag: last DIV had a zero divisor
- bus  out  WIDTH  internal bus value
- bus_err  out  1  more than one bus driver active
- ir_q, mar_q, mdr_q, pc_q, y_q, hi_q, lo_q  out  WIDTH each  register contents
- z_q  out  2*WIDTH  Z register contents
- dbg_sel  in  $clog2(NREGS)  debug register select
- dbg_q  out  WIDTH  register[dbg_sel], combinational

Behaviour:

Reset:
- clr low, asynchronously: all registers, Z, busy, done and div0 go to 0.
- Reset mid-operation aborts MUL/DIV and leaves no partial Z update.

Bus:
- Combinational OR of all enabled sources. No driver gives 0.
- bus_err = 1 when two or more drive strobes are high (reg_out bits included). The bus still carries the OR.
- R0 with ba_out = 1 contributes 0.

Register loads:
- All loads happen on the clk edge from bus.
- inc_pc without pc_in: PC <= PC + PC_STEP, wrapping modulo 2^WIDTH.
- pc_in has priority over inc_pc.
- MDR loads mdata_in when mdr_read = 1, else bus.

Combinational ALU (operand A = y_q, B = bus), loaded into Z on z_in:
- ADD, SUB, AND, OR, NOT, NEG: result into Z low; Z high = sign extension of the result.
- SHR, SHRA, SHL, ROR, ROL: shift amount is B[$clog2(WIDTH)-1:0].

Multi-cycle MUL/DIV (handshake):
- Trigger: start = 1 while idle, with alu_op = MUL or DIV, captures A = y_q and B = bus.
- Cycle 0: start edge; busy rises.
- Cycles 1..WIDTH: one iteration each. MUL is shift-add on magnitudes; DIV is restoring division on magnitudes.
- Cycle WIDTH+1: Z loaded, busy falls, done = 1 for exactly one cycle.
- MUL result: Z = signed 2W-bit product.
- DIV result: Z high = remainder (takes the sign of the dividend), Z low = quotient (truncated toward zero).
- DIV with B = 0: Z high = A, Z low = all ones, div0 = 1. div0 is cleared by the next start.
- start while busy is ignored.
- z_in while busy is ignored; Z is owned by the unit.
- start with any other alu_op is ignored.
- Bus and other registers remain fully usable while busy.
- hi_in/lo_in while busy load normally.

Decomposition:
- Package dp_pkg: ALU op encodings as localparams:
  - ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHRA=5, SHL=6, ROR=7, ROL=8, NEG=9, NOT=10, MUL=11, DIV=12.
  - Also holds the width-derived constants.
- One sub-module: muldiv_iter.
  - Owns the FSM: IDLE -> RUN (iteration counter 0..WIDTH-1) -> FIN -> IDLE.
  - Owns the sign fix-up.
  - Drives busy, done and div0, and presents the result plus a load strobe to Z.

Test Plan:
- Reset/PC: clr low, then high; pc_in with bus = 0x10 (from c_data), then inc_pc for 3 cycles -> pc_q = 0x13, all other registers 0. PC = 0xFFFFFFFF with inc_pc -> 0.
- Register/bus: load R3 = 0x0000_00A5 via c_out; reg_out[3] -> bus = 0xA5. Assert reg_out[0] and ba_out -> bus = 0. Assert c_out and pc_out together -> bus_err = 1.
- ALU: Y = 7, bus = -3, ADD -> z_q low = 4, z_q high = 0. SHRA of 0x8000_0000 by 4 -> 0xF800_0000. ROL of 0x8000_0001 by 1 -> 0x0000_0003.
- MUL: Y = -6, bus = 7, start -> busy for 33 cycles, done pulses in cycle 33, z_q = 0xFFFF_FFFF_FFFF_FFD6 (-42).
- DIV: Y = -17, bus = 5 -> quotient -3, remainder -2. Y = 9, bus = 0 -> z_q = {9, 0xFFFF_FFFF}, div0 = 1. A second start while busy -> no effect.
- Abort/collision: clr low at iteration 10 of a MUL -> busy = 0, z_q = 0. z_in mid-operation -> Z unchanged until done. Re-run with WIDTH = 16, NREGS = 8 -> MUL latency 17 cycles.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared definitions for the single-bus datapath: ALU op encodings and default sizing.
package dp_pkg;

    localparam int OP_W      = 5;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREGS = 16;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OP_W-1:0] OP_AND  = 5'd2;
    localparam logic [OP_W-1:0] OP_OR   = 5'd3;
    localparam logic [OP_W-1:0] OP_SHR  = 5'd4;
    localparam logic [OP_W-1:0] OP_SHRA = 5'd5;
    localparam logic [OP_W-1:0] OP_SHL  = 5'd6;
    localparam logic [OP_W-1:0] OP_ROR  = 5'd7;
    localparam logic [OP_W-1:0] OP_ROL  = 5'd8;
    localparam logic [OP_W-1:0] OP_NEG  = 5'd9;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd10;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd11;
    localparam logic [OP_W-1:0] OP_DIV  = 5'd12;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative signed multiply / restoring divide on magnitudes, one bit per cycle,
// with sign fix-up at the end and a one-cycle load strobe toward Z.
module muldiv_iter
    import dp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               div0,
    output logic               z_ld,
    output logic [2*WIDTH-1:0] z_res
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div, sa, sb, bz;
    logic [WIDTH-1:0] a_raw, m, q, rem;
    logic [WIDTH:0]   add_sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rmd;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    // MUL: {rem,q} is the shifting product; DIV: rem is the partial remainder, q shifts dividend out / quotient in
    always_comb begin
        add_sum = {1'b0, rem} + (q[0] ? {1'b0, m} : '0);
        diff    = {rem, q[WIDTH-1]} - {1'b0, m};
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            div0   <= 1'b0;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            bz     <= 1'b0;
            a_raw  <= '0;
            m      <= '0;
            q      <= '0;
            rem    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && is_muldiv(op)) begin
                        state  <= S_RUN;
                        busy   <= 1'b1;
                        div0   <= 1'b0;
                        cnt    <= '0;
                        is_div <= (op == OP_DIV);
                        sa     <= a[WIDTH-1];
                        sb     <= b[WIDTH-1];
                        bz     <= (b == '0);
                        a_raw  <= a;
                        rem    <= '0;
                        if (op == OP_DIV) begin
                            q <= mag(a);
                            m <= mag(b);
                        end else begin
                            m <= mag(a);
                            q <= mag(b);
                        end
                    end
                end
                S_RUN: begin
                    if (is_div) begin
                        rem <= diff[WIDTH] ? {rem[WIDTH-2:0], q[WIDTH-1]} : diff[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], ~diff[WIDTH]};
                    end else begin
                        rem <= add_sum[WIDTH:1];
                        q   <= {add_sum[0], q[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= S_FIN;
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    div0  <= is_div & bz;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Quotient truncates toward zero; remainder follows the dividend's sign
    always_comb begin
        prod = {rem, q};
        quo  = (sa ^ sb) ? -q : q;
        rmd  = sa ? -rem : rem;
        if (!is_div)
            z_res = (sa ^ sb) ? -prod : prod;
        else if (bz)
            z_res = {a_raw, {WIDTH{1'b1}}};
        else
            z_res = {rmd, quo};
        z_ld = (state == S_FIN);
    end

endmodule

// File: rtl/param_bus_datapath.sv
// Single-bus CPU datapath: register file, PC/IR/MAR/MDR/Y/Z/HI/LO, combinational ALU
// and an iterative MUL/DIV unit that owns Z while it runs.
module param_bus_datapath
    import dp_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREGS   = DEF_NREGS,
    parameter int PC_STEP = 1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [NREGS-1:0]         reg_in,
    input  logic [NREGS-1:0]         reg_out,
    input  logic                     ba_out,
    input  logic                     pc_in,
    input  logic                     pc_out,
    input  logic                     inc_pc,
    input  logic                     ir_in,
    input  logic                     mar_in,
    input  logic                     y_in,
    input  logic                     hi_in,
    input  logic                     lo_in,
    input  logic                     mdr_in,
    input  logic                     mdr_read,
    input  logic                     mdr_out,
    input  logic                     z_in,
    input  logic                     zhi_out,
    input  logic                     zlo_out,
    input  logic                     hi_out,
    input  logic                     lo_out,
    input  logic                     c_out,
    input  logic                     inport_out,
    input  logic [WIDTH-1:0]         c_data,
    input  logic [WIDTH-1:0]         inport_data,
    input  logic [WIDTH-1:0]         mdata_in,
    input  logic [OP_W-1:0]          alu_op,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     div0,
    output logic [WIDTH-1:0]         bus,
    output logic                     bus_err,
    output logic [WIDTH-1:0]         ir_q,
    output logic [WIDTH-1:0]         mar_q,
    output logic [WIDTH-1:0]         mdr_q,
    output logic [WIDTH-1:0]         pc_q,
    output logic [WIDTH-1:0]         y_q,
    output logic [WIDTH-1:0]         hi_q,
    output logic [WIDTH-1:0]         lo_q,
    output logic [2*WIDTH-1:0]       z_q,
    input  logic [$clog2(NREGS)-1:0] dbg_sel,
    output logic [WIDTH-1:0]         dbg_q
);

    localparam int SW = $clog2(WIDTH);

    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]            alu_y;
    logic [SW-1:0]               sh;
    logic                        md_ld;
    logic [2*WIDTH-1:0]          md_res;

    // Bus is a wired-OR of every enabled source; R0 reads as zero under ba_out
    always_comb begin
        bus = '0;
        for (int i = 0; i < NREGS; i++)
            if (reg_out[i] && !(i == 0 && ba_out))
                bus = bus | regs[i];
        if (pc_out)     bus = bus | pc_q;
        if (mdr_out)    bus = bus | mdr_q;
        if (zhi_out)    bus = bus | z_q[2*WIDTH-1:WIDTH];
        if (zlo_out)    bus = bus | z_q[WIDTH-1:0];
        if (hi_out)     bus = bus | hi_q;
        if (lo_out)     bus = bus | lo_q;
        if (c_out)      bus = bus | c_data;
        if (inport_out) bus = bus | inport_data;
        bus_err = ($countones({reg_out, pc_out, mdr_out, zhi_out, zlo_out,
                               hi_out, lo_out, c_out, inport_out}) > 1);
    end

    always_comb begin
        sh    = bus[SW-1:0];
        alu_y = '0;
        case (alu_op)
            OP_ADD:  alu_y = y_q + bus;
            OP_SUB:  alu_y = y_q - bus;
            OP_AND:  alu_y = y_q & bus;
            OP_OR:   alu_y = y_q | bus;
            OP_SHR:  alu_y = y_q >> sh;
            OP_SHRA: alu_y = WIDTH'($signed(y_q) >>> sh);
            OP_SHL:  alu_y = y_q << sh;
            OP_ROR:  alu_y = (y_q >> sh) | (y_q << (WIDTH - int'(sh)));
            OP_ROL:  alu_y = (y_q << sh) | (y_q >> (WIDTH - int'(sh)));
            OP_NEG:  alu_y = -bus;
            OP_NOT:  alu_y = ~bus;
            default: alu_y = '0;
        endcase
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .op    (alu_op),
        .a     (y_q),
        .b     (bus),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .z_ld  (md_ld),
        .z_res (md_res)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            regs  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                if (reg_in[i]) regs[i] <= bus;
            if (pc_in)       pc_q <= bus;
            else if (inc_pc) pc_q <= pc_q + WIDTH'(PC_STEP);
            if (ir_in)  ir_q  <= bus;
            if (mar_in) mar_q <= bus;
            if (mdr_in) mdr_q <= mdr_read ? mdata_in : bus;
            if (y_in)   y_q   <= bus;
            if (hi_in)  hi_q  <= bus;
            if (lo_in)  lo_q  <= bus;
            // The MUL/DIV unit owns Z from start until its result lands
            if (md_ld)
                z_q <= md_res;
            else if (z_in && !busy)
                z_q <= {{WIDTH{alu_y[WIDTH-1]}}, alu_y};
        end
    end

    always_comb begin
        dbg_q = '0;
        if (int'(dbg_sel) < NREGS)
            dbg_q = regs[dbg_sel];
    end

endmodule

// File: tb/tb_param_bus_datapath.sv
// Directed plus randomized checks of the datapath against a behavioural arithmetic model.
module tb_param_bus_datapath;
    import dp_pkg::*;

    logic clk, clr;
    logic [15:0] reg_in, reg_out;
    logic ba_out, pc_in, pc_out, inc_pc, ir_in, mar_in, y_in, hi_in, lo_in;
    logic mdr_in, mdr_read, mdr_out, z_in, zhi_out, zlo_out, hi_out, lo_out, c_out, inport_out;
    logic [31:0] c_data, inport_data, mdata_in;
    logic [4:0]  alu_op;
    logic start, busy, done, div0, bus_err;
    logic [31:0] bus, ir_q, mar_q, mdr_q, pc_q, y_q, hi_q, lo_q, dbg_q;
    logic [63:0] z_q;
    logic [3:0]  dbg_sel;

    // Narrow instance for the parameter re-run
    logic [15:0] b_c_data;
    logic        b_c_out, b_y_in, b_start;
    logic [4:0]  b_alu_op;
    logic        b_busy, b_done, b_div0, b_bus_err;
    logic [15:0] b_bus, b_ir_q, b_mar_q, b_mdr_q, b_pc_q, b_y_q, b_hi_q, b_lo_q, b_dbg_q;
    logic [31:0] b_z_q;

    int n_tests = 0;
    int n_fail  = 0;

    param_bus_datapath dut (
        .clk(clk), .clr(clr), .reg_in(reg_in), .reg_out(reg_out), .ba_out(ba_out),
        .pc_in(pc_in), .pc_out(pc_out), .inc_pc(inc_pc), .ir_in(ir_in), .mar_in(mar_in),
        .y_in(y_in), .hi_in(hi_in), .lo_in(lo_in), .mdr_in(mdr_in), .mdr_read(mdr_read),
        .mdr_out(mdr_out), .z_in(z_in), .zhi_out(zhi_out), .zlo_out(zlo_out),
        .hi_out(hi_out), .lo_out(lo_out), .c_out(c_out), .inport_out(inport_out),
        .c_data(c_data), .inport_data(inport_data), .mdata_in(mdata_in), .alu_op(alu_op),
        .start(start), .busy(busy), .done(done), .div0(div0), .bus(bus), .bus_err(bus_err),
        .ir_q(ir_q), .mar_q(mar_q), .mdr_q(mdr_q), .pc_q(pc_q), .y_q(y_q), .hi_q(hi_q),
        .lo_q(lo_q), .z_q(z_q), .dbg_sel(dbg_sel), .dbg_q(dbg_q)
    );

    param_bus_datapath #(.WIDTH(16), .NREGS(8)) dut16 (
        .clk(clk), .clr(clr), .reg_in('0), .reg_out('0), .ba_out(1'b0),
        .pc_in(1'b0), .pc_out(1'b0), .inc_pc(1'b0), .ir_in(1'b0), .mar_in(1'b0),
        .y_in(b_y_in), .hi_in(1'b0), .lo_in(1'b0), .mdr_in(1'b0), .mdr_read(1'b0),
        .mdr_out(1'b0), .z_in(1'b0), .zhi_out(1'b0), .zlo_out(1'b0),
        .hi_out(1'b0), .lo_out(1'b0), .c_out(b_c_out), .inport_out(1'b0),
        .c_data(b_c_data), .inport_data('0), .mdata_in('0), .alu_op(b_alu_op),
        .start(b_start), .busy(b_busy), .done(b_done), .div0(b_div0), .bus(b_bus),
        .bus_err(b_bus_err), .ir_q(b_ir_q), .mar_q(b_mar_q), .mdr_q(b_mdr_q), .pc_q(b_pc_q),
        .y_q(b_y_q), .hi_q(b_hi_q), .lo_q(b_lo_q), .z_q(b_z_q), .dbg_sel(3'd0), .dbg_q(b_dbg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl_clear();
        reg_in = '0; reg_out = '0; ba_out = 0; pc_in = 0; pc_out = 0; inc_pc = 0;
        ir_in = 0; mar_in = 0; y_in = 0; hi_in = 0; lo_in = 0; mdr_in = 0; mdr_read = 0;
        mdr_out = 0; z_in = 0; zhi_out = 0; zlo_out = 0; hi_out = 0; lo_out = 0;
        c_out = 0; inport_out = 0; start = 0; alu_op = OP_ADD;
        b_c_out = 0; b_y_in = 0; b_start = 0; b_alu_op = OP_ADD;
    endtask

    task automatic set_y(input logic [31:0] v);
        c_data = v; c_out = 1; y_in = 1;
        tick();
        ctrl_clear();
    endtask

    task automatic do_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        set_y(a);
        c_data = b; c_out = 1; alu_op = op; z_in = 1;
        tick();
        ctrl_clear();
    endtask

    // Launch MUL/DIV and measure edges from the start edge to the done pulse and busy cycles
    task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        set_y(a);
        c_data = b; c_out = 1; alu_op = op; start = 1;
        tick();
        ctrl_clear();
        lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int s;
        logic [31:0] r;
        s = int'(b[4:0]);
        r = a;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SHR:  repeat (s) r = {1'b0, r[31:1]};
            OP_SHRA: repeat (s) r = {r[31], r[31:1]};
            OP_SHL:  repeat (s) r = {r[30:0], 1'b0};
            OP_ROR:  repeat (s) r = {r[0], r[31:1]};
            OP_ROL:  repeat (s) r = {r[30:0], r[31]};
            OP_NEG:  r = 32'd0 - b;
            OP_NOT:  r = ~b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] md_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_MUL) begin
            p = sa * sb;
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        qv = sa / sb;
        rv = sa % sb;
        return {rv[31:0], qv[31:0]};
    endfunction

    initial begin
        int lat, bcnt, seen;
        logic [4:0]  rop;
        logic [31:0] ra, rb, rexp;
        logic [63:0] zprev, mexp;
        int ia, ib, ip;
        logic [31:0] pexp;

        clr = 0;
        ctrl_clear();
        c_data = '0; inport_data = '0; mdata_in = '0; dbg_sel = '0; b_c_data = '0;
        #12;
        chk("rst_pc", pc_q, 0);
        chk("rst_z", z_q, 0);
        chk("rst_busy", {busy, done, div0}, 0);
        clr = 1;
        tick();

        // PC load, increment and priority
        c_data = 32'h10; c_out = 1; pc_in = 1; tick(); ctrl_clear();
        inc_pc = 1; repeat (3) tick(); ctrl_clear();
        chk("pc_inc", pc_q, 32'h13);
        chk("others_zero", {ir_q, mar_q, mdr_q, y_q, hi_q, lo_q}, 0);

        // Register file, bus, R0 masking, contention
        c_data = 32'hA5; c_out = 1; reg_in[3] = 1; tick(); ctrl_clear();
        reg_out[3] = 1; #1;
        chk("bus_r3", bus, 32'hA5);
        chk("bus_err_single", bus_err, 0);
        ctrl_clear();
        dbg_sel = 4'd3; #1;
        chk("dbg_r3", dbg_q, 32'hA5);
        c_data = 32'h55; c_out = 1; reg_in[0] = 1; tick(); ctrl_clear();
        reg_out[0] = 1; #1;
        chk("bus_r0", bus, 32'h55);
        ba_out = 1; #1;
        chk("bus_r0_ba", bus, 0);
        ctrl_clear();
        c_data = 32'h100; c_out = 1; pc_out = 1; #1;
        chk("bus_or", bus, 32'h113);
        chk("bus_err", bus_err, 1);
        ctrl_clear();

        mdata_in = 32'hDEAD_BEEF; mdr_in = 1; mdr_read = 1; tick(); ctrl_clear();
        chk("mdr_mem", mdr_q, 32'hDEAD_BEEF);
        c_data = 32'h77; c_out = 1; mdr_in = 1; ir_in = 1; mar_in = 1; tick(); ctrl_clear();
        chk("mdr_bus", {mdr_q, ir_q, mar_q}, {32'h77, 32'h77, 32'h77});

        c_data = 32'hFFFF_FFFF; c_out = 1; pc_in = 1; tick(); ctrl_clear();
        inc_pc = 1; tick(); ctrl_clear();
        chk("pc_wrap", pc_q, 0);
        c_data = 32'h5; c_out = 1; pc_in = 1; inc_pc = 1; tick(); ctrl_clear();
        chk("pc_prio", pc_q, 32'h5);

        // Directed ALU points
        do_alu(OP_ADD, 32'd7, -32'sd3);
        chk("add", z_q, 64'd4);
        do_alu(OP_SUB, 32'd3, 32'd5);
        chk("sub_sext", z_q, 64'hFFFF_FFFF_FFFF_FFFE);
        do_alu(OP_SHRA, 32'h8000_0000, 32'd4);
        chk("shra", z_q[31:0], 32'hF800_0000);
        do_alu(OP_ROL, 32'h8000_0001, 32'd1);
        chk("rol", z_q[31:0], 32'h0000_0003);

        for (int k = 0; k < 24; k++) begin
            rop = 5'($urandom_range(0, 10));
            ra = $urandom;
            rb = (k % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            do_alu(rop, ra, rb);
            rexp = alu_ref(rop, ra, rb);
            chk("alu_rand_lo", z_q[31:0], rexp);
            if (rop inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEG, OP_NOT})
                chk("alu_rand_hi", z_q[63:32], {32{rexp[31]}});
        end

        // MUL/DIV directed
        run_md(OP_MUL, -32'sd6, 32'd7, lat, bcnt);
        chk("mul_lat", lat, 33);
        chk("mul_busy", bcnt, 33);
        chk("mul_res", z_q, 64'hFFFF_FFFF_FFFF_FFD6);
        tick();
        chk("done_pulse", {done, busy}, 0);

        run_md(OP_DIV, -32'sd17, 32'd5, lat, bcnt);
        chk("div_res", z_q, {32'hFFFF_FFFE, 32'hFFFF_FFFD});

        run_md(OP_DIV, 32'd9, 32'd0, lat, bcnt);
        chk("div0_res", z_q, {32'd9, 32'hFFFF_FFFF});
        chk("div0_flag", div0, 1);

        c_data = 32'd7; c_out = 1; alu_op = OP_ADD; start = 1; tick(); ctrl_clear();
        chk("start_bad_op", {busy, div0}, 2'b01);

        // Second start while busy must not disturb the running DIV; div0 clears on the accepted start
        set_y(32'd100);
        c_data = 32'd7; c_out = 1; alu_op = OP_DIV; start = 1; tick(); ctrl_clear();
        chk("div0_clear", {busy, div0}, 2'b10);
        repeat (5) tick();
        c_data = 32'd3; c_out = 1; alu_op = OP_MUL; start = 1; tick(); ctrl_clear();
        lat = 6;
        while (!done && lat < 100) begin tick(); lat++; end
        chk("restart_lat", lat, 33);
        chk("restart_res", z_q, {32'd2, 32'd14});

        // z_in during busy is ignored; hi_in still loads
        zprev = z_q;
        set_y(32'd3);
        c_data = 32'd5; c_out = 1; alu_op = OP_MUL; start = 1; tick(); ctrl_clear();
        repeat (3) tick();
        c_data = 32'd1; c_out = 1; alu_op = OP_ADD; z_in = 1; hi_in = 1; tick(); ctrl_clear();
        chk("z_in_busy", z_q, zprev);
        chk("hi_busy", hi_q, 32'd1);
        lat = 0;
        while (!done && lat < 100) begin tick(); lat++; end
        chk("mul_after_zin", z_q, 64'd15);

        for (int k = 0; k < 8; k++) begin
            rop = (k % 2 == 0) ? OP_MUL : OP_DIV;
            ra = (k == 5) ? 32'h8000_0000 : $urandom;
            rb = (k == 3) ? 32'd0 : ((k == 5) ? 32'hFFFF_FFFF : $urandom);
            if (k == 7) rb = 32'($urandom_range(1, 300));
            run_md(rop, ra, rb, lat, bcnt);
            mexp = md_ref(rop, ra, rb);
            chk("md_rand", z_q, mexp);
            chk("md_rand_lat", lat, 33);
        end

        // Narrow build: latency WIDTH+1
        b_c_data = 16'hFFFA; b_c_out = 1; b_y_in = 1; tick(); ctrl_clear();
        b_c_data = 16'd7; b_c_out = 1; b_alu_op = OP_MUL; b_start = 1; tick(); ctrl_clear();
        lat = 0;
        while (!b_done && lat < 100) begin tick(); lat++; end
        chk("w16_lat", lat, 17);
        chk("w16_mul", b_z_q, 32'hFFFF_FFD6);
        for (int k = 0; k < 3; k++) begin
            ia = int'($signed(16'($urandom)));
            ib = int'($signed(16'($urandom)));
            b_c_data = 16'(ia); b_c_out = 1; b_y_in = 1; tick(); ctrl_clear();
            b_c_data = 16'(ib); b_c_out = 1; b_alu_op = OP_MUL; b_start = 1; tick(); ctrl_clear();
            lat = 0;
            while (!b_done && lat < 100) begin tick(); lat++; end
            ip = ia * ib;
            pexp = 32'(ip);
            chk("w16_mul_rand", b_z_q, pexp);
        end

        // Abort mid-MUL: reset clears everything and no late Z update appears
        set_y(32'd1234);
        c_data = 32'd99; c_out = 1; alu_op = OP_MUL; start = 1; tick(); ctrl_clear();
        repeat (10) tick();
        clr = 0; #1;
        chk("abort_busy", {busy, done}, 0);
        chk("abort_z", z_q, 0);
        #2 clr = 1;
        seen = 0;
        repeat (40) begin tick(); if (done || busy) seen = 1; end
        chk("abort_quiet", {seen[0], z_q}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
